uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `top_TX` UART transmitter between `NUM_REQ` byte requesters. It captures one requester's byte and parity configuration and presents them to `top_TX` as a single-cycle `Data_Valid` load. It then tracks the transmitter's `busy` through the end of the frame before granting again. It sits directly in front of `top_TX` in the UART TX subsystem.

---
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that loads one requester's byte and parity
// config into a shared top_TX, then tracks busy through the end of the frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_par_en,
    input  logic [NUM_REQ-1:0]         req_par_typ,
    output logic [NUM_REQ-1:0]         ack,
    input  logic                       busy,
    output logic [7:0]                 P_DATA,
    output logic                       Data_Valid,
    output logic                       Par_EN,
    output logic                       Par_TYP,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       err_timeout
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] last_grant, pick, idx;
    logic          found, grant, tmo;
    logic [CW-1:0] cnt, cnt_n;

    // Scan downward so the nearest requester after last_grant is the final winner.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_REQ; k > 0; k--) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign grant    = (state == IDLE) && found;
    assign arb_busy = state != IDLE;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tmo     = 1'b0;
        case (state)
            IDLE:       state_n = found ? LOAD : IDLE;
            LOAD: begin
                state_n = WAIT_START;
                cnt_n   = '0;
            end
            WAIT_START: begin
                if (busy)
                    state_n = WAIT_DONE;
                else if (cnt == CW'(START_TIMEOUT - 1)) begin
                    state_n = IDLE;
                    tmo     = 1'b1;
                end else
                    cnt_n = cnt + 1'b1;
            end
            WAIT_DONE:  state_n = busy ? WAIT_DONE : IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
            grant_id    <= '0;
            P_DATA      <= '0;
            Par_EN      <= 1'b0;
            Par_TYP     <= 1'b0;
            Data_Valid  <= 1'b0;
            ack         <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            err_timeout <= tmo;
            Data_Valid  <= grant;
            ack         <= grant ? NUM_REQ'(1) << pick : '0;
            if (grant) begin
                last_grant <= pick;
                grant_id   <= pick;
                P_DATA     <= req_data[{pick, 3'b000} +: 8];
                Par_EN     <= req_par_en[pick];
                Par_TYP    <= req_par_typ[pick];
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a simple top_TX busy model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_par_en = '0;
    logic [N-1:0]   req_par_typ = '0;
    logic [N-1:0]   ack;
    logic           busy;
    logic [7:0]     P_DATA;
    logic           Data_Valid, Par_EN, Par_TYP, arb_busy, err_timeout;
    logic [1:0]     grant_id;

    int   total = 0;
    int   bad = 0;
    int   frame = 3;
    logic tx_en = 1'b1;
    int   tx_cnt = 0;
    int   lowcnt = 0;
    int   dv_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .req_par_en(req_par_en), .req_par_typ(req_par_typ), .ack(ack),
        .busy(busy), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Par_EN(Par_EN),
        .Par_TYP(Par_TYP), .grant_id(grant_id), .arb_busy(arb_busy),
        .err_timeout(err_timeout)
    );

    // top_TX stand-in: busy rises the cycle after the load and lasts frame cycles.
    always @(posedge clk) begin
        if (rst)
            tx_cnt <= 0;
        else if (Data_Valid && tx_en)
            tx_cnt <= frame;
        else if (tx_cnt > 0)
            tx_cnt <= tx_cnt - 1;
        lowcnt <= busy ? 0 : lowcnt + 1;
        if (Data_Valid) dv_cnt <= dv_cnt + 1;
        if (err_timeout) err_cnt <= err_cnt + 1;
    end
    assign busy = tx_cnt > 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_dv(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!Data_Valid && n < 40);
        chk({tag, "_dv_seen"}, Data_Valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((arb_busy || busy) && n < 60);
        chk({tag, "_idle"}, {arb_busy, busy}, 0);
    endtask

    logic [7:0] rr_d[5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    int         rr_g[5] = '{0, 1, 2, 3, 0};

    initial begin
        int   n, dv0, err0;
        logic cfg_ok;

        do_reset();
        chk("reset_outs", {P_DATA, Par_EN, Par_TYP, Data_Valid, ack, grant_id, arb_busy, err_timeout}, 0);

        // Single byte 0xDA with odd parity.
        dv0 = dv_cnt;
        req_data[7:0] = 8'hDA;
        req_par_en = 4'b0001;
        req_par_typ = 4'b0001;
        req = 4'b0001;
        wait_dv("single");
        chk("single_data", P_DATA, 8'hDA);
        chk("single_par", {Par_EN, Par_TYP}, 2'b11);
        chk("single_ack", ack, 4'b0001);
        chk("single_gid", grant_id, 0);
        chk("single_frame_bits", {P_DATA, 1'b0}, 9'b1_1011_0100);
        req = '0;
        tick();
        chk("single_pulse_len", {Data_Valid, ack}, 0);
        n = 0;
        while (!busy && n < 10) begin tick(); n++; end
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk("single_arb_busy_after_fall", arb_busy, 1);
        tick();
        chk("single_arb_idle", arb_busy, 0);
        chk("single_dv_count", dv_cnt - dv0, 1);
        chk("single_hold", {P_DATA, grant_id}, {8'hDA, 2'd0});

        // Round robin with all requesters held high.
        do_reset();
        req_par_en = '0;
        req_par_typ = '0;
        req_data = 32'h4332_2110;
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_dv("rr");
            chk("rr_data", P_DATA, rr_d[i]);
            chk("rr_gid", grant_id, rr_g[i]);
            chk("rr_ack", ack, 32'd1 << rr_g[i]);
            chk("rr_dv_busy", busy, 0);
            if (i > 0) chk("rr_gap", lowcnt >= 2, 1);
            if (i == 4) req = '0;
            tick();
            chk("rr_ack_len", {Data_Valid, ack}, 0);
        end
        wait_idle("rr");

        // Simultaneous requests with wrap: 3 wins over 1 after 1 was served.
        do_reset();
        req = 4'b0010;
        wait_dv("wrap1");
        chk("wrap_first_gid", grant_id, 1);
        req = 4'b1010;
        wait_dv("wrap3");
        chk("wrap_second_gid", grant_id, 3);
        chk("wrap_second_ack", ack, 4'b1000);
        req = 4'b0010;
        wait_dv("wrap1b");
        chk("wrap_third_gid", grant_id, 1);
        req = '0;
        wait_idle("wrap");

        // Start timeout with busy held low.
        tx_en = 1'b0;
        req = 4'b0100;
        wait_dv("to");
        chk("to_ack", ack, 4'b0100);
        chk("to_data", P_DATA, 8'h32);
        req = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!err_timeout && n < 20);
        chk("to_cycle", n, 5);
        chk("to_idle", arb_busy, 0);
        tick();
        chk("to_pulse_len", err_timeout, 0);
        tx_en = 1'b1;
        err0 = err_cnt;
        req = 4'b0100;
        wait_dv("to_retry");
        chk("to_retry_ack", ack, 4'b0100);
        req = '0;
        wait_idle("to_retry");
        chk("to_retry_no_err", err_cnt - err0, 0);

        // Config isolation and inter-frame gap.
        do_reset();
        req_data[15:0] = 16'h5AA5;
        req_par_en = 4'b0010;
        req_par_typ = 4'b0001;
        req = 4'b0011;
        wait_dv("cfg0");
        chk("cfg0_data", P_DATA, 8'hA5);
        chk("cfg0_par", {Par_EN, Par_TYP}, 2'b01);
        req = 4'b0010;
        cfg_ok = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (!Data_Valid && {Par_EN, Par_TYP} != 2'b01) cfg_ok = 1'b0;
        end while (!Data_Valid && n < 40);
        chk("cfg_stable", cfg_ok, 1);
        chk("cfg1_dv_seen", Data_Valid, 1);
        chk("cfg1_data", P_DATA, 8'h5A);
        chk("cfg1_par", {Par_EN, Par_TYP}, 2'b10);
        chk("cfg1_dv_busy", busy, 0);
        chk("cfg1_gap", lowcnt >= 2, 1);
        req = '0;
        wait_idle("cfg");

        // Reset during WAIT_DONE.
        req_data[23:16] = 8'h77;
        req = 4'b0100;
        wait_dv("mid");
        req = '0;
        tick();
        tick();
        chk("mid_in_frame", {arb_busy, busy}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset_outs", {P_DATA, Par_EN, Par_TYP, Data_Valid, ack, grant_id, arb_busy, err_timeout}, 0);
        req_data = 32'h4D00_003C;
        req = 4'b1001;
        wait_dv("mid_after");
        chk("mid_after_gid", grant_id, 0);
        chk("mid_after_data", P_DATA, 8'h3C);
        req = 4'b1000;
        wait_dv("mid_after3");
        chk("mid_after3_gid", grant_id, 3);
        req = '0;
        wait_idle("mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
